// File: rtl/key_debouncer.sv
// key_debouncer: per-channel two-flop synchronizer, debounce counter and press/release pulses.
// Define KEY_DEBOUNCER_AUTOREPEAT_EN to add held-key auto-repeat pulses on key_press.
module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              RST_N,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int              CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   C_TERM     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_KEYS-1:0] C_RAW_IDLE = ACTIVE_LOW ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) ||
      REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("key_debouncer: parameter out of legal range");
  end

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] r_level;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [N_KEYS-1:0] w_pressed;
  logic [N_KEYS-1:0] w_accept;
  logic [N_KEYS-1:0] w_rpt;
  logic [CW-1:0]     r_cnt [N_KEYS];

  // Synchronizer resets to the raw "released" level so no phantom press after reset.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= C_RAW_IDLE;
      r_sync2 <= C_RAW_IDLE;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_accept[i] = (w_pressed[i] != r_level[i]) && (r_cnt[i] == C_TERM);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_KEYS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if ((w_pressed[i] == r_level[i]) || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_level   <= r_level ^ w_accept;
      r_press   <= (w_accept & ~r_level) | w_rpt;
      r_release <= w_accept & r_level;
    end
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int            HW          = $clog2((REPEAT_DELAY > REPEAT_PERIOD ?
                                                  REPEAT_DELAY : REPEAT_PERIOD) + 1);
  localparam logic [HW-1:0] C_DELAY_LD  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] C_PERIOD_LD = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] r_hold [N_KEYS];

  // A releasing edge never repeats; the hold timer is only meaningful while level is high.
  always_comb begin
    w_rpt = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_rpt[i] = r_level[i] && !w_accept[i] && (r_hold[i] == '0);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_KEYS; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (w_accept[i]) begin
          r_hold[i] <= r_level[i] ? '0 : C_DELAY_LD;
        end else if (r_level[i] && (r_hold[i] == '0)) begin
          r_hold[i] <= C_PERIOD_LD;
        end else if (r_level[i]) begin
          r_hold[i] <= r_hold[i] - HW'(1);
        end
      end
    end
  end
`else
  assign w_rpt = '0;
`endif

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer: run-length reference model compared every cycle,
// plus hand-computed edge-count expectations.
module tb_key_debouncer;

  localparam int N     = 4;
  localparam int D     = 8;
  localparam int R_DLY = 20;
  localparam int R_PER = 5;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam logic [N-1:0] RPT_EXP = 4'b0001;
`else
  localparam logic [N-1:0] RPT_EXP = 4'b0000;
`endif

  logic         CLOCK_50;
  logic         RST_N;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;

  int n_tests;
  int n_fail;

  key_debouncer #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(R_DLY), .REPEAT_PERIOD(R_PER)
  ) dut (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a new level is accepted once the pressed value, seen two edges late,
  // has stayed different from the level for exactly D consecutive samples.
  logic [N-1:0] hist [$];
  logic [N-1:0] m_level, m_press, m_release;
  int           cyc;
  int           acc_edge [N];

  always @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
    end else begin
      cyc++;
      m_press   = '0;
      m_release = '0;
      for (int c = 0; c < N; c++) begin
        int  last;
        int  run;
        logic x;
        last = hist.size() - 1;
        x    = hist[last-1][c];
        run  = 0;
        if (x != m_level[c]) begin
          for (int k = last - 1; k >= 0; k--) begin
            if (hist[k][c] == x) run++;
            else break;
          end
        end
        if (run == D) begin
          m_level[c] = x;
          if (x) begin
            m_press[c]  = 1'b1;
            acc_edge[c] = cyc;
          end else begin
            m_release[c] = 1'b1;
          end
        end else if (m_level[c]) begin
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
          if ((cyc - acc_edge[c] >= R_DLY) && ((cyc - acc_edge[c] - R_DLY) % R_PER == 0))
            m_press[c] = 1'b1;
`endif
        end
      end
      hist.push_back(~key_raw);
      if (hist.size() > D + 4) void'(hist.pop_front());
    end
  end

  always @(negedge CLOCK_50) begin
    check("level", key_level, m_level);
    check("press", key_press, m_press);
    check("release", key_release, m_release);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    RST_N   = 1'b0;
    key_raw = 4'hF;
    step(3);
    check("rst_level", key_level, 4'b0000);
    check("rst_press", key_press, 4'b0000);
    RST_N = 1'b1;
    step(3);
    check("idle_level", key_level, 4'b0000);

    // key 0 press: accept on the 10th edge after the change
    key_raw = 4'hE;
    step(9);
    check("k0_pre_level", key_level, 4'b0000);
    step(1);
    check("k0_acc_level", key_level, 4'b0001);
    check("k0_acc_press", key_press, 4'b0001);
    step(1);
    check("k0_after_press", key_press, 4'b0000);

    // key 0 release
    key_raw = 4'hF;
    step(9);
    check("k0r_pre_level", key_level, 4'b0001);
    step(1);
    check("k0r_release", key_release, 4'b0001);
    check("k0r_level", key_level, 4'b0000);
    check("k0r_press", key_press, 4'b0000);
    step(1);
    check("k0r_after", key_release, 4'b0000);

    // key 1: 7-cycle glitch rejected, then full count accepted
    key_raw = 4'hD;
    step(7);
    key_raw = 4'hF;
    step(12);
    check("k1_glitch_level", key_level, 4'b0000);
    key_raw = 4'hD;
    step(9);
    check("k1_pre_level", key_level, 4'b0000);
    step(1);
    check("k1_press", key_press, 4'b0010);
    key_raw = 4'hF;
    step(12);
    check("k1_released", key_level, 4'b0000);

    // keys 2 and 3 together
    key_raw = 4'h3;
    step(10);
    check("k23_press", key_press, 4'b1100);
    check("k23_level", key_level, 4'b1100);
    key_raw = 4'hF;
    step(10);
    check("k23_release", key_release, 4'b1100);
    step(2);

    // reset while key 2 is held and key 0 is mid-count
    key_raw = 4'hB;
    step(10);
    check("k2_level", key_level, 4'b0100);
    key_raw = 4'hA;
    step(5);
    RST_N = 1'b0;
    #1;
    check("midrst_level", key_level, 4'b0000);
    check("midrst_press", key_press, 4'b0000);
    step(2);
    RST_N = 1'b1;
    step(1);
    check("postrst_press", key_press, 4'b0000);
    step(8);
    check("postrst_pre_level", key_level, 4'b0000);
    step(1);
    check("postrst_press2", key_press, 4'b0101);
    check("postrst_level", key_level, 4'b0101);
    key_raw = 4'hF;
    step(12);
    check("postrst_rel", key_level, 4'b0000);

    // long hold on key 0: repeats only when auto-repeat is built in
    key_raw = 4'hE;
    step(10);
    check("hold_acc", key_press, 4'b0001);
    step(20);
    check("hold_rpt20", key_press, RPT_EXP);
    step(1);
    check("hold_rpt21", key_press, 4'b0000);
    step(4);
    check("hold_rpt25", key_press, RPT_EXP);
    step(5);
    check("hold_rpt30", key_press, RPT_EXP);
    key_raw = 4'hF;
    step(5);
    check("hold_rpt35", key_press, RPT_EXP);
    step(5);
    check("hold_rel", key_release, 4'b0001);
    check("hold_rel_press", key_press, 4'b0000);
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 The module SHALL have parameter N_KEYS, default 4, giving the number of independent key/switch channels.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz), giving the stable-input cycles required before a level change is accepted; legal range is 2..2^20.
REQ-003 The module SHALL have parameter ACTIVE_LOW, default 1, where 1 means a raw input of 0 is "pressed" (the board KEY buttons).
REQ-004 The module SHALL have parameters REPEAT_DELAY (default 25000000) and REPEAT_PERIOD (default 5000000), which are used only under REQ-019.
REQ-005 CLOCK_50  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-007 key_raw  input  N_KEYS  asynchronous board inputs (KEY or SW bits).
REQ-008 key_level  output  N_KEYS  debounced level per channel, 1 = pressed, independent of ACTIVE_LOW.
REQ-009 key_press  output  N_KEYS  one-cycle pulse per accepted pressed transition.
REQ-010 key_release  output  N_KEYS  one-cycle pulse per accepted released transition.

Function
REQ-011 Each key_raw bit SHALL pass through a two-flop synchronizer; after synchronization, polarity SHALL be normalised per ACTIVE_LOW so that 1 = pressed.
REQ-012 Each channel SHALL hold a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits; the counter clears on any cycle where the synchronized value equals key_level and increments otherwise.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 and the synchronized value still differs, on that edge key_level SHALL toggle, the counter SHALL clear, and the matching pulse (key_press for 0->1, key_release for 1->0) SHALL assert for exactly one cycle.
REQ-014 Latency: for a raw input that is stable from clock edge 1 onward, key_level and the pulse SHALL update on edge DEBOUNCE_CYCLES+2.
REQ-015 A glitch, meaning any return to the current key_level before the count completes, SHALL restart the count from 0, and no pulse SHALL be generated.
REQ-016 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce simultaneous pulses on the same cycle.
REQ-017 key_press and key_release SHALL never be high together on one channel, and a channel SHALL never produce two pulses on consecutive cycles.

Reset
REQ-018 While RST_N=0: key_level=0, key_press=0, key_release=0, all counters and synchronizer flops cleared to the "released" value. Deassertion mid-press SHALL require the full debounce interval before key_level rises; no pulse SHALL be emitted on the first cycle after reset.

Configuration
REQ-019 Macro KEY_DEBOUNCER_AUTOREPEAT_EN SHALL control auto-repeat: when defined, each channel has a per-channel hold counter; while key_level=1, key_press SHALL re-pulse REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles until release.
REQ-020 Under KEY_DEBOUNCER_AUTOREPEAT_EN, the hold counter SHALL clear on release and on reset, and no repeat pulse SHALL coincide with key_release.
REQ-021 Without KEY_DEBOUNCER_AUTOREPEAT_EN, key_press SHALL pulse exactly once per accepted press, REPEAT_* SHALL be ignored, and no hold-counter logic SHALL be synthesized.

Verification
REQ-022 Set N_KEYS=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1. Drive key_raw[0] 1->0 stable -> key_level[0]=1 and key_press[0] high for one cycle on edge 10; other bits stay 0.
REQ-023 Drive key_raw[1] low for 7 cycles, then high -> key_level[1] and key_press[1] never assert; then hold low for 8+ cycles -> press accepted after the full count.
REQ-024 Release key_raw[0] (0->1) stable after it is pressed -> key_release[0] pulses once on edge 10 after the change and key_level[0]=0; key_press[0] stays 0.
REQ-025 Press key_raw[2] and key_raw[3] on the same edge -> both key_press bits pulse on the same cycle; assert RST_N=0 mid-count on a third channel -> outputs go to 0 immediately, and no pulse follows deassertion until 10 stable cycles have elapsed.
REQ-026 With KEY_DEBOUNCER_AUTOREPEAT_EN defined, REPEAT_DELAY=20 and REPEAT_PERIOD=5, hold key 0 -> key_press pulses at accept, accept+20, accept+25, accept+30; release -> key_release only.
